imem_loader: RTL and testbench

- Write-side counterpart of the byte-addressed instruction memory (512 x 8, big-endian 16-bit words).
- Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them into the memory's byte write port, high byte first at the even address.
- Holds the CPU while loading and reports completion, words loaded and error flags.

---
 rtl/imem_loader.sv | 189 ++++++++++++++++++
 tb/tb_imem_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Purpose : streams bytes into the instruction memory write port, assembling
//           big-endian 16-bit words (high byte at the even address) and
//           holding the CPU while the load is in progress.
// Latency : byte handshaken in cycle N is on mem_we/mem_addr/mem_wdata in N+1;
//           done pulses one cycle after the last write (1 cycle after start
//           for an empty load).
// Backpressure: in_ready is high only while a byte is expected; in_valid low
//           stalls indefinitely. start is ignored unless idle.
//
// Ports   : clk, rst_n (async active-low); start/base_addr/word_count load
//           request; in_valid/in_data/in_ready byte stream; mem_we/mem_addr/
//           mem_wdata registered memory byte write; busy/cpu_hold/done status;
//           words_loaded, err_wrap (sticky), chk_err (sticky).
// Option  : define IMEM_LOADER_CHECKSUM_EN to consume a trailing 16-bit
//           checksum word after the data and flag chk_err on mismatch.
module imem_loader #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic [CNT_W-1:0]  words_loaded,
    output logic              err_wrap,
    output logic              chk_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_FIN, S_CHK_HI, S_CHK_LO} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_FIN} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic              wrap_q, wrap_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
    logic [7:0]        hi_q, hi_d;
    logic              chk_q, chk_d;
`endif

    // After the last data byte the FSM stays in FIN while that byte's write
    // is still on the memory port, so done lands one cycle after it.
    assign in_ready = (state_q == S_HI) || (state_q == S_LO)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state_q == S_CHK_HI) || (state_q == S_CHK_LO)
`endif
                   ;
    assign done         = (state_q == S_FIN) && !we_q;
    assign busy         = (state_q != S_IDLE) && !done;
    assign cpu_hold     = busy;
    assign hs           = in_valid && in_ready;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = words_q;
    assign err_wrap     = wrap_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign chk_err      = chk_q;
`else
    assign chk_err      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        wrap_d  = wrap_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        hi_d    = hi_q;
        chk_d   = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Word-align the base: bit 0 is dropped.
                    ptr_d   = base_addr & ~ADDR_W'(1);
                    cnt_d   = word_count;
                    words_d = '0;
                    wrap_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    chk_d   = 1'b0;
                    state_d = (word_count == '0) ? S_CHK_HI : S_HI;
`else
                    state_d = (word_count == '0) ? S_FIN : S_HI;
`endif
                end
            end
            S_HI, S_LO: begin
                if (hs) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    if (ptr_q == '1) wrap_d = 1'b1;
                    if (state_q == S_HI) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        hi_d = in_data;
`endif
                        state_d = S_LO;
                    end else begin
                        words_d = words_q + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + {hi_q, in_data};
                        state_d = (words_d == cnt_q) ? S_CHK_HI : S_HI;
`else
                        state_d = (words_d == cnt_q) ? S_FIN : S_HI;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK_HI: begin
                if (hs) begin
                    hi_d    = in_data;
                    state_d = S_CHK_LO;
                end
            end
            S_CHK_LO: begin
                if (hs) begin
                    if ({hi_q, in_data} != sum_q) chk_d = 1'b1;
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                if (!we_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            words_q <= '0;
            wrap_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
            hi_q    <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            wrap_q  <= wrap_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            chk_q   <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a byte-count based transaction model predicts every
// output each cycle; directed loads add hand-computed literal expectations.
// Tracks the memory contents written through the DUT's byte write port.
module tb_imem_loader;
    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] base_addr = '0;
    logic [8:0] word_count = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, mem_we, busy, cpu_hold, done, err_wrap, chk_err;
    logic [8:0] mem_addr, words_loaded;
    logic [7:0] mem_wdata;

    imem_loader #(.ADDR_W(9), .CNT_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .cpu_hold(cpu_hold), .done(done),
        .words_loaded(words_loaded), .err_wrap(err_wrap), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int n_writes = 0;
    bit cmp_en = 1'b0;
    logic [7:0] dut_mem [512];

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model ----------------
    // phase 0 idle, 1 accepting bytes, 2 finishing (m_cd cycles to done)
    int         m_phase = 0, m_cd = 0, m_idx = 0, m_total = 0, m_ndata = 0;
    logic [8:0] m_addr = '0;
    logic [7:0] m_prev = '0;
    logic [15:0] m_sum = '0;
    logic       e_we = 0, e_done = 0, e_busy = 0, e_ready = 0, e_wrap = 0, e_chk = 0;
    logic [8:0] e_addr = '0, e_words = '0;
    logic [7:0] e_wdata = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; e_we = 0; e_done = 0; e_busy = 0; e_ready = 0;
            e_wrap = 0; e_chk = 0; e_words = '0; e_addr = '0; e_wdata = '0;
        end else begin
            e_we = 0;
            case (m_phase)
                0: if (start) begin
                    m_addr  = base_addr & 9'h1FE;
                    m_ndata = 2 * int'(word_count);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    m_total = m_ndata + 2;
`else
                    m_total = m_ndata;
`endif
                    m_idx = 0; m_sum = '0; e_words = '0; e_wrap = 0; e_chk = 0;
                    if (m_total == 0) begin m_phase = 2; m_cd = 1; end
                    else m_phase = 1;
                end
                1: if (in_valid) begin
                    if (m_idx < m_ndata) begin
                        e_we = 1; e_addr = m_addr; e_wdata = in_data;
                        if (m_addr == 9'h1FF) e_wrap = 1;
                        m_addr = m_addr + 9'd1;
                        if (m_idx % 2 == 1) begin
                            e_words = e_words + 9'd1;
                            m_sum = m_sum + {m_prev, in_data};
                        end
                    end else if (m_idx == m_ndata + 1 && {m_prev, in_data} != m_sum) begin
                        e_chk = 1;
                    end
                    m_prev = in_data;
                    m_idx++;
                    if (m_idx == m_total) begin m_phase = 2; m_cd = e_we ? 2 : 1; end
                end
                default: begin m_cd--; if (m_cd == 0) m_phase = 0; end
            endcase
            e_done  = (m_phase == 2 && m_cd == 1);
            e_busy  = (m_phase != 0) && !e_done;
            e_ready = (m_phase == 1);
        end
    end

    // ---------------- per-cycle compare and memory capture ----------------
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            dut_mem[mem_addr] = mem_wdata;
            n_writes++;
        end
        if (rst_n && cmp_en) begin
            check("in_ready", in_ready, e_ready);
            check("busy", busy, e_busy);
            check("cpu_hold", cpu_hold, e_busy);
            check("done", done, e_done);
            check("mem_we", mem_we, e_we);
            check("words_loaded", words_loaded, e_words);
            check("err_wrap", err_wrap, e_wrap);
            check("chk_err", chk_err, e_chk);
            if (e_we) begin
                check("mem_addr", mem_addr, e_addr);
                check("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] b, input logic [8:0] n, output int sc);
        start = 1; base_addr = b; word_count = n;
        sc = cyc;
        tick();
        start = 0;
    endtask

    task automatic send(input bq_t b, input bit stall);
        foreach (b[i]) begin
            int t = 0;
            if (stall) begin in_valid = 0; tick(); end
            in_valid = 1; in_data = b[i];
            while (!in_ready && t < 50) begin tick(); t++; end
            if (!in_ready) check("send_timeout", 0, 1);
            tick();
        end
        in_valid = 0;
    endtask

    task automatic wait_done(output int dc);
        int t = 0;
        while (!done && t < 100) begin tick(); t++; end
        if (!done) check("done_timeout", 0, 1);
        dc = cyc;
    endtask

    // start + stream (+ checksum word in checksum builds) + wait for done
    task automatic load(input logic [8:0] b, input logic [8:0] n, input bq_t bytes,
                        input bit stall, input bit add_chk, output int sc, output int dc);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [15:0] s = '0;
        if (add_chk) begin
            for (int i = 0; i + 1 < bytes.size(); i += 2) s = s + {bytes[i], bytes[i+1]};
            bytes.push_back(s[15:8]);
            bytes.push_back(s[7:0]);
        end
`endif
        do_start(b, n, sc);
        send(bytes, stall);
        wait_done(dc);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int LAT2 = 7;
    localparam int LAT0 = 3;
`else
    localparam int LAT2 = 6;
    localparam int LAT0 = 1;
`endif

    initial begin
        bq_t q;
        int sc, dc, w0;
        for (int i = 0; i < 512; i++) dut_mem[i] = 8'hEE;

        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_words", words_loaded, 0);
        check("rst_err_wrap", err_wrap, 0);
        check("rst_chk_err", chk_err, 0);
        rst_n = 1;
        tick();
        cmp_en = 1;

        // Reset in the middle of a load
        do_start(9'h010, 9'd3, sc);
        q = {8'hA1, 8'hA2, 8'hA3};
        send(q, 0);
        tick();
        check("midrst_words_before", words_loaded, 1);
        rst_n = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_mem_we", mem_we, 0);
        check("midrst_words", words_loaded, 0);
        tick();
        rst_n = 1;
        tick();
        check("midrst_idle_ready", in_ready, 0);
        check("midrst_m10", dut_mem[9'h010], 8'hA1);
        check("midrst_m11", dut_mem[9'h011], 8'hA2);
        check("midrst_m12", dut_mem[9'h012], 8'hA3);
        check("midrst_m13_untouched", dut_mem[9'h013], 8'hEE);

        // Basic load
        w0 = n_writes;
        q = {8'h12, 8'h34, 8'hAB, 8'hCD};
        load(9'h000, 9'd2, q, 0, 1, sc, dc);
        check("basic_done_latency", dc - sc, LAT2);
        check("basic_words", words_loaded, 2);
        check("basic_nwrites", n_writes - w0, 4);
        check("basic_m0", dut_mem[0], 8'h12);
        check("basic_m3", dut_mem[3], 8'hCD);
        check("basic_word_pc0", {dut_mem[0], dut_mem[1]}, 16'h1234);
        check("basic_word_pc2", {dut_mem[2], dut_mem[3]}, 16'hABCD);
        tick();

        // Odd base, stalled stream
        w0 = n_writes;
        q = {8'hBE, 8'hEF};
        load(9'h005, 9'd1, q, 1, 1, sc, dc);
        check("odd_m4", dut_mem[4], 8'hBE);
        check("odd_m5", dut_mem[5], 8'hEF);
        check("odd_nwrites", n_writes - w0, 2);
        tick();

        // Address wrap
        q = {8'h11, 8'h22, 8'h33, 8'h44};
        load(9'h1FE, 9'd2, q, 0, 1, sc, dc);
        check("wrap_m1fe", dut_mem[9'h1FE], 8'h11);
        check("wrap_m1ff", dut_mem[9'h1FF], 8'h22);
        check("wrap_m000", dut_mem[9'h000], 8'h33);
        check("wrap_m001", dut_mem[9'h001], 8'h44);
        check("wrap_flag_at_done", err_wrap, 1);
        tick();
        check("wrap_flag_sticky", err_wrap, 1);

        // Zero count; start clears the wrap flag
        w0 = n_writes;
        q = {};
        load(9'h100, 9'd0, q, 0, 1, sc, dc);
        check("zero_done_latency", dc - sc, LAT0);
        check("zero_wrap_cleared", err_wrap, 0);
        check("zero_nwrites", n_writes - w0, 0);
        tick();

        // start while busy is ignored
        w0 = n_writes;
        do_start(9'h020, 9'd1, sc);
        start = 1; word_count = 9'd5;
        tick();
        start = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        q = {8'h5A, 8'hA5, 8'h5A, 8'hA5};
`else
        q = {8'h5A, 8'hA5};
`endif
        send(q, 0);
        wait_done(dc);
        check("ign_words", words_loaded, 1);
        check("ign_nwrites", n_writes - w0, 2);
        check("ign_m20", dut_mem[9'h020], 8'h5A);
        tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
        w0 = n_writes;
        q = {8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00};
        load(9'h040, 9'd2, q, 0, 0, sc, dc);
        check("chk_ok_flag", chk_err, 0);
        check("chk_ok_nwrites", n_writes - w0, 4);
        tick();
        q = {8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h01};
        load(9'h040, 9'd2, q, 0, 0, sc, dc);
        check("chk_bad_flag", chk_err, 1);
        tick();
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
